period_phase_scheduler: RTL and testbench
=========================================

Name: period_phase_scheduler

Overview:
- Single-clock scheduler for four staggered period outputs used by ECU timing logic.
- A prescaler generates service ticks. Each tick grants one round-robin slot to one of the four period channels, ch0..ch3 in order.
- Each channel has a programmable half-period count and start offset.
- A control FSM arms, runs and cleanly halts the rotation; a config port loads channel settings while idle.

Parameters:
c_DEFAULT_HALF, 8'd99, reset value of all four half-period registers
c_START0, 8'd49, reset start offset ch0
c_START1, 8'd0, reset start offset ch1
c_START2, 8'd49, reset start offset ch2
c_START3, 8'd0, reset start offset ch3
c_INIT_LEVEL, 4'b1100, level loaded into o_periodPhased at reset/arm (bit n = ch n)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  run request (level)
i_prescale  in  8  tick every i_prescale+1 clocks; latched in ARM
i_cfgWrite  in  1  config write strobe
i_cfgAddr  in  3  0-3: half-period ch0-3; 4-7: start offset ch0-3
i_cfgData  in  8  config write data
o_cfgAck  out  1  1-cycle pulse, write accepted
o_cfgErr  out  1  1-cycle pulse, write rejected
o_phaseStrobe  out  4  one-hot 1-cycle service strobe
o_periodPhased  out  4  period output levels
o_periodEdge  out  4  1-cycle pulse on each toggle of o_periodPhased
o_busy  out  1  high in ARM/RUN/HALT
o_state  out  2  IDLE=0, ARM=1, RUN=2, HALT=3

Behaviour:
- Reset (async, takes effect with no clock edge):
  - state=IDLE; phase pointer=0; prescale counter=0.
  - Half regs=c_DEFAULT_HALF; offset regs=c_STARTn; channel counters=0.
  - o_periodPhased=c_INIT_LEVEL; o_phaseStrobe, o_periodEdge, o_cfgAck, o_cfgErr, o_busy = 0.
- IDLE:
  - No strobes; levels hold.
  - i_enable=1 -> ARM.
- ARM (exactly 1 cycle):
  - Counter n <= offset n; o_periodPhased <= c_INIT_LEVEL.
  - Latch i_prescale; prescale counter=0; phase=0.
  - -> RUN.
- RUN, tick rule:
  - A tick occurs in any cycle where prescale counter == latched prescale; counter then wraps to 0, otherwise it increments.
  - Prescale 0 gives a tick every cycle.
- RUN, servicing channel k=phase on a tick edge:
  - o_phaseStrobe <= one-hot(k).
  - If counter k >= half k: o_periodPhased[k] toggles, counter k <= 0, o_periodEdge[k] <= 1.
  - Else counter k increments.
  - phase <= phase+1 (2-bit wrap).
  - Strobe, new level and edge all become visible in the cycle after the tick.
  - Non-tick cycles: strobe and edge are 0.
- RUN -> HALT when i_enable=0.
- HALT:
  - Ticks and service continue until ch3 has been serviced, then -> IDLE on the next edge.
  - If phase==0 on HALT entry, -> IDLE on the next edge with no further service.
  - i_enable is ignored in HALT.
  - Levels hold in IDLE afterwards; the next enable re-arms from offsets and c_INIT_LEVEL.
- Half/offset edge cases:
  - Half=0: the channel toggles on every service.
  - Offset >= half: toggles on the first service.
  - Counter is 8-bit and never exceeds 255.
- Config write:
  - Accepted only when state==IDLE: register updated at that edge, o_cfgAck pulses next cycle.
  - In any other state: register unchanged, o_cfgErr pulses next cycle.
  - Write and enable in the same IDLE cycle: the write is accepted and ARM uses the new value.
  - Address selects exactly one register.
- Outputs registered; o_busy = (state != IDLE).

Test Plan:
1. Assert i_reset with clock stopped -> o_state=0, o_periodPhased=4'b1100, all pulses 0; default regs verified by running with prescale 0: first ch0 toggle on its 51st service, then every 100 ch0 services.
2. Write half=1 to all channels, offsets 0, prescale 0, enable -> o_phaseStrobe rotates 0001,0010,0100,1000 each cycle; each channel toggles every 2nd service (period 16 clocks), o_periodEdge pulses aligned with toggles.
3. Prescale 3, half=0 -> strobes 4 clocks apart; each channel toggles on every service.
4. cfgWrite addr 0 data 8'd5 in RUN -> o_cfgErr pulse, o_cfgAck 0, half ch0 still old value on next arm; same write in IDLE -> o_cfgAck pulse.
5. Drop i_enable when phase=2 -> ch2 then ch3 strobes occur, then IDLE, no further strobes, levels held; drop when phase=0 -> IDLE next cycle, no strobe.
6. Async i_reset mid-RUN between clock edges -> outputs return to reset values immediately; enable after release -> ARM then clean rotation from ch0.

Source files
------------

// File: rtl/period_phase_scheduler_if.sv
// Bus bundle for period_phase_scheduler: run control, config write port and
// the scheduled period outputs. The DUT side uses the slave modport.
interface period_phase_scheduler_if;
  logic       i_enable;
  logic [7:0] i_prescale;
  logic       i_cfgWrite;
  logic [2:0] i_cfgAddr;
  logic [7:0] i_cfgData;
  logic       o_cfgAck;
  logic       o_cfgErr;
  logic [3:0] o_phaseStrobe;
  logic [3:0] o_periodPhased;
  logic [3:0] o_periodEdge;
  logic       o_busy;
  logic [1:0] o_state;

  modport slave (
    input  i_enable, i_prescale, i_cfgWrite, i_cfgAddr, i_cfgData,
    output o_cfgAck, o_cfgErr, o_phaseStrobe, o_periodPhased, o_periodEdge,
           o_busy, o_state
  );

  modport master (
    output i_enable, i_prescale, i_cfgWrite, i_cfgAddr, i_cfgData,
    input  o_cfgAck, o_cfgErr, o_phaseStrobe, o_periodPhased, o_periodEdge,
           o_busy, o_state
  );
endinterface

// File: rtl/period_phase_scheduler.sv
// Round-robin scheduler for four staggered period outputs. A prescaler makes
// service ticks; each tick services one channel, toggling it when its count expires.
module period_phase_scheduler #(
  parameter logic [7:0] c_DEFAULT_HALF = 8'd99,
  parameter logic [7:0] c_START0       = 8'd49,
  parameter logic [7:0] c_START1       = 8'd0,
  parameter logic [7:0] c_START2       = 8'd49,
  parameter logic [7:0] c_START3       = 8'd0,
  parameter logic [3:0] c_INIT_LEVEL   = 4'b1100
) (
  input logic                   i_clock,
  input logic                   i_reset,
  period_phase_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t     state_q;
  logic [1:0] phase_q;
  logic [7:0] pre_cnt_q;
  logic [7:0] pre_lat_q;
  logic [7:0] half_q [4];
  logic [7:0] off_q  [4];
  logic [7:0] cnt_q  [4];
  logic [3:0] lvl_q;
  logic [3:0] strobe_q;
  logic [3:0] edge_q;
  logic       ack_q;
  logic       err_q;
  logic       busy_q;

  logic tick_d;
  logic hit_d;
  logic halt_done_d;
  logic cfg_ok_d;

  assign tick_d      = (pre_cnt_q == pre_lat_q);
  assign hit_d       = (cnt_q[phase_q] >= half_q[phase_q]);
  // HALT stops once the rotation is back at ch0, i.e. after ch3 was serviced.
  assign halt_done_d = (state_q == S_HALT) && (phase_q == 2'd0);
  assign cfg_ok_d    = (state_q == S_IDLE);

  // Config port: i_cfgWrite is a single-cycle request, always answered one
  // cycle later by exactly one of o_cfgAck (applied) or o_cfgErr (dropped).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 2'd0;
      pre_cnt_q <= 8'd0;
      pre_lat_q <= 8'd0;
      half_q    <= '{c_DEFAULT_HALF, c_DEFAULT_HALF, c_DEFAULT_HALF, c_DEFAULT_HALF};
      off_q     <= '{c_START0, c_START1, c_START2, c_START3};
      cnt_q     <= '{8'd0, 8'd0, 8'd0, 8'd0};
      lvl_q     <= c_INIT_LEVEL;
      strobe_q  <= 4'd0;
      edge_q    <= 4'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      strobe_q <= 4'd0;
      edge_q   <= 4'd0;
      ack_q    <= bus.i_cfgWrite && cfg_ok_d;
      err_q    <= bus.i_cfgWrite && !cfg_ok_d;
      if (bus.i_cfgWrite && cfg_ok_d) begin
        if (!bus.i_cfgAddr[2]) half_q[bus.i_cfgAddr[1:0]] <= bus.i_cfgData;
        else                   off_q[bus.i_cfgAddr[1:0]]  <= bus.i_cfgData;
      end
      case (state_q)
        S_IDLE: begin
          busy_q <= bus.i_enable;
          if (bus.i_enable) state_q <= S_ARM;
        end
        S_ARM: begin
          cnt_q     <= off_q;
          lvl_q     <= c_INIT_LEVEL;
          pre_lat_q <= bus.i_prescale;
          pre_cnt_q <= 8'd0;
          phase_q   <= 2'd0;
          busy_q    <= 1'b1;
          state_q   <= S_RUN;
        end
        default: begin
          if (halt_done_d) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            busy_q    <= 1'b1;
            pre_cnt_q <= tick_d ? 8'd0 : pre_cnt_q + 8'd1;
            if (tick_d) begin
              strobe_q <= 4'b0001 << phase_q;
              phase_q  <= phase_q + 2'd1;
              if (hit_d) begin
                lvl_q[phase_q]  <= ~lvl_q[phase_q];
                edge_q[phase_q] <= 1'b1;
                cnt_q[phase_q]  <= 8'd0;
              end else begin
                cnt_q[phase_q]  <= cnt_q[phase_q] + 8'd1;
              end
            end
            if (state_q == S_RUN && !bus.i_enable) state_q <= S_HALT;
          end
        end
      endcase
    end
  end

  assign bus.o_cfgAck       = ack_q;
  assign bus.o_cfgErr       = err_q;
  assign bus.o_phaseStrobe  = strobe_q;
  assign bus.o_periodPhased = lvl_q;
  assign bus.o_periodEdge   = edge_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_state        = state_q;

endmodule

// File: tb/tb_period_phase_scheduler.sv
// Bench for period_phase_scheduler: directed scenarios followed by random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_period_phase_scheduler;

  logic clk;
  logic rst;
  logic clk_run;
  int   n_checks;
  int   n_fail;

  period_phase_scheduler_if bus ();

  period_phase_scheduler dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  // Clock / reset block
  initial begin
    clk     = 1'b0;
    clk_run = 1'b0;
  end
  always #5 if (clk_run) clk = ~clk;

  // Behavioural model state
  int         m_state;
  int         m_phase;
  int         m_pc;
  int         m_pl;
  int         m_half [4];
  int         m_off  [4];
  int         m_cnt  [4];
  logic [3:0] m_lvl;
  logic [3:0] e_strobe;
  logic [3:0] e_edge;
  logic       e_ack;
  logic       e_err;
  int         ch0_svc;
  int         ch0_edge_svc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_pc = 0; m_pl = 0;
    for (int i = 0; i < 4; i++) begin
      m_half[i] = 99;
      m_cnt[i]  = 0;
    end
    m_off[0] = 49; m_off[1] = 0; m_off[2] = 49; m_off[3] = 0;
    m_lvl = 4'b1100;
    e_strobe = 4'd0; e_edge = 4'd0; e_ack = 1'b0; e_err = 1'b0;
  endtask

  // One clock of the reference behaviour, using the inputs currently driven.
  task automatic model_step();
    int  k;
    bit  tick;
    e_strobe = 4'd0; e_edge = 4'd0; e_ack = 1'b0; e_err = 1'b0;
    if (bus.i_cfgWrite) begin
      if (m_state == 0) begin
        e_ack = 1'b1;
        if (bus.i_cfgAddr < 4) m_half[bus.i_cfgAddr] = bus.i_cfgData;
        else                   m_off[bus.i_cfgAddr - 4] = bus.i_cfgData;
      end else begin
        e_err = 1'b1;
      end
    end
    if (m_state == 0) begin
      if (bus.i_enable) m_state = 1;
    end else if (m_state == 1) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = m_off[i];
      m_lvl = 4'b1100; m_pl = bus.i_prescale; m_pc = 0; m_phase = 0; m_state = 2;
    end else if (m_state == 3 && m_phase == 0) begin
      m_state = 0;
    end else begin
      tick = (m_pc == m_pl);
      m_pc = tick ? 0 : m_pc + 1;
      if (tick) begin
        k = m_phase;
        e_strobe[k] = 1'b1;
        if (m_cnt[k] >= m_half[k]) begin
          m_lvl[k] = ~m_lvl[k];
          e_edge[k] = 1'b1;
          m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        m_phase = (m_phase + 1) % 4;
      end
      if (m_state == 2 && !bus.i_enable) m_state = 3;
    end
  endtask

  task automatic compare_outputs();
    check("state",  32'(bus.o_state),        32'(m_state));
    check("busy",   32'(bus.o_busy),         32'(m_state != 0));
    check("strobe", 32'(bus.o_phaseStrobe),  32'(e_strobe));
    check("level",  32'(bus.o_periodPhased), 32'(m_lvl));
    check("edge",   32'(bus.o_periodEdge),   32'(e_edge));
    check("ack",    32'(bus.o_cfgAck),       32'(e_ack));
    check("err",    32'(bus.o_cfgErr),       32'(e_err));
  endtask

  // Driver tasks
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
    if (bus.o_phaseStrobe[0]) ch0_svc++;
    if (bus.o_periodEdge[0]) ch0_edge_svc.push_back(ch0_svc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [7:0] data);
    bus.i_cfgWrite = 1'b1;
    bus.i_cfgAddr  = addr;
    bus.i_cfgData  = data;
    step();
    bus.i_cfgWrite = 1'b0;
  endtask

  task automatic go_idle();
    bus.i_enable = 1'b0;
    for (int i = 0; i < 2000 && m_state != 0; i++) step();
    if (m_state != 0) check("idle_timeout", 32'(m_state), 32'd0);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  32'(bus.o_state),        32'd0);
    check({tag, "_level"},  32'(bus.o_periodPhased), 32'hC);
    check({tag, "_strobe"}, 32'(bus.o_phaseStrobe),  32'd0);
    check({tag, "_edge"},   32'(bus.o_periodEdge),   32'd0);
    check({tag, "_ack"},    32'(bus.o_cfgAck),       32'd0);
    check({tag, "_err"},    32'(bus.o_cfgErr),       32'd0);
    check({tag, "_busy"},   32'(bus.o_busy),         32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ch0_svc  = 0;
    rst      = 1'b0;
    bus.i_enable   = 1'b0;
    bus.i_prescale = 8'd0;
    bus.i_cfgWrite = 1'b0;
    bus.i_cfgAddr  = 3'd0;
    bus.i_cfgData  = 8'd0;
    model_reset();

    // Reset with the clock stopped
    #2 rst = 1'b1;
    #3 check_reset_values("rst_noclk");
    clk_run = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    // Default registers, prescale 0
    ch0_svc = 0;
    ch0_edge_svc.delete();
    bus.i_enable = 1'b1;
    run(620);
    check("ch0_edges", 32'(ch0_edge_svc.size() >= 2), 32'd1);
    if (ch0_edge_svc.size() >= 2) begin
      check("ch0_first_edge_svc",  32'(ch0_edge_svc[0]), 32'd51);
      check("ch0_second_edge_svc", 32'(ch0_edge_svc[1]), 32'd151);
    end
    go_idle();

    // half=1, offset 0, prescale 0: fast rotation
    for (int i = 0; i < 4; i++) cfg_write(3'(i), 8'd1);
    for (int i = 4; i < 8; i++) cfg_write(3'(i), 8'd0);
    bus.i_prescale = 8'd0;
    bus.i_enable = 1'b1;
    run(40);
    // Rejected write while running
    cfg_write(3'd0, 8'd5);
    run(5);
    go_idle();

    // half=0, prescale 3
    for (int i = 0; i < 4; i++) cfg_write(3'(i), 8'd0);
    bus.i_prescale = 8'd3;
    bus.i_enable = 1'b1;
    run(40);
    go_idle();
    cfg_write(3'd0, 8'd5);

    // Drop enable with phase 2 on the next service
    bus.i_prescale = 8'd0;
    bus.i_enable = 1'b1;
    run(9);
    for (int i = 0; i < 8 && m_phase != 2; i++) step();
    check("phase2_reached", 32'(m_phase), 32'd2);
    bus.i_enable = 1'b0;
    run(8);

    // Drop enable with phase 0 on a non-tick cycle
    bus.i_prescale = 8'd3;
    bus.i_enable = 1'b1;
    run(10);
    for (int i = 0; i < 40 && !(m_phase == 0 && m_pc != m_pl && m_state == 2); i++) step();
    check("phase0_reached", 32'(m_phase), 32'd0);
    bus.i_enable = 1'b0;
    run(6);

    // Asynchronous reset between clock edges while running
    bus.i_prescale = 8'd0;
    bus.i_enable = 1'b1;
    run(23);
    #3 rst = 1'b1;
    #1 check_reset_values("rst_async");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    run(30);
    go_idle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) bus.i_enable = ~bus.i_enable;
      bus.i_prescale = 8'($urandom_range(0, 3));
      bus.i_cfgWrite = ($urandom_range(0, 3) == 0);
      bus.i_cfgAddr  = 3'($urandom_range(0, 7));
      bus.i_cfgData  = 8'($urandom_range(0, 6));
      step();
    end
    bus.i_cfgWrite = 1'b0;
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
